// File: rtl/alu_reg_sched.sv
// Single-command ALU/register-file scheduler: READ -> EXEC -> WB (-> RESP) per accepted command.
// Define ALU_SCHED_RR_ARB_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_reg_sched #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd0_valid_i,
    output logic               cmd0_ready_o,
    input  logic [3:0]         cmd0_op_i,
    input  logic [RADDR_W-1:0] cmd0_rs1_i,
    input  logic [RADDR_W-1:0] cmd0_rs2_i,
    input  logic [RADDR_W-1:0] cmd0_rd_i,
    input  logic               cmd1_valid_i,
    output logic               cmd1_ready_o,
    input  logic [3:0]         cmd1_op_i,
    input  logic [RADDR_W-1:0] cmd1_rs1_i,
    input  logic [RADDR_W-1:0] cmd1_rs2_i,
    input  logic [RADDR_W-1:0] cmd1_rd_i,
    output logic [RADDR_W-1:0] reg_raddr1_o,
    output logic [RADDR_W-1:0] reg_raddr2_o,
    input  logic [DATA_W-1:0]  reg_rdata1_i,
    input  logic [DATA_W-1:0]  reg_rdata2_i,
    output logic               reg_wen_o,
    output logic [RADDR_W-1:0] reg_waddr_o,
    output logic [DATA_W-1:0]  reg_wdata_o,
    output logic [DATA_W-1:0]  alu_data1_o,
    output logic [DATA_W-1:0]  alu_data2_o,
    output logic [3:0]         alu_op_o,
    input  logic [DATA_W-1:0]  alu_result_i,
    output logic               done_valid_o,
    output logic               done_id_o,
    output logic [DATA_W-1:0]  done_result_o,
    input  logic               done_ready_i,
    output logic               busy_o
);

    typedef enum logic [2:0] {IDLE, READ, EXEC, WB, RESP} state_t;

    state_t               state_q, state_d;
    logic [3:0]           op_q, op_d;
    logic [RADDR_W-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic                 id_q, id_d;
    logic [DATA_W-1:0]    opa_q, opa_d, opb_q, opb_d, res_q, res_d;
    logic                 grant0, grant1;

`ifdef ALU_SCHED_RR_ARB_EN
    logic last_q, last_d;

    // On contention, serve whichever requester was not served last.
    always_comb begin
        grant0 = cmd0_valid_i && (!cmd1_valid_i || last_q);
        grant1 = cmd1_valid_i && (!cmd0_valid_i || !last_q);
        last_d = last_q;
        if (state_q == IDLE && (grant0 || grant1)) begin
            last_d = grant1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        grant0 = cmd0_valid_i;
        grant1 = cmd1_valid_i && !cmd0_valid_i;
    end
`endif

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        rd_d          = rd_q;
        id_d          = id_q;
        opa_d         = opa_q;
        opb_d         = opb_q;
        res_d         = res_q;
        cmd0_ready_o  = 1'b0;
        cmd1_ready_o  = 1'b0;
        reg_raddr1_o  = '0;
        reg_raddr2_o  = '0;
        reg_wen_o     = 1'b0;
        reg_waddr_o   = '0;
        reg_wdata_o   = '0;
        alu_data1_o   = '0;
        alu_data2_o   = '0;
        alu_op_o      = '0;
        done_valid_o  = 1'b0;
        done_id_o     = 1'b0;
        done_result_o = '0;
        busy_o        = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                // Ready is masked while reset is held so every output reads 0 then.
                cmd0_ready_o = grant0 && reset;
                cmd1_ready_o = grant1 && reset;
                if (grant0 || grant1) begin
                    id_d    = grant1;
                    op_d    = grant1 ? cmd1_op_i  : cmd0_op_i;
                    rs1_d   = grant1 ? cmd1_rs1_i : cmd0_rs1_i;
                    rs2_d   = grant1 ? cmd1_rs2_i : cmd0_rs2_i;
                    rd_d    = grant1 ? cmd1_rd_i  : cmd0_rd_i;
                    state_d = READ;
                end
            end
            READ: begin
                reg_raddr1_o = rs1_q;
                reg_raddr2_o = rs2_q;
                opa_d        = reg_rdata1_i;
                opb_d        = reg_rdata2_i;
                state_d      = EXEC;
            end
            EXEC: begin
                alu_data1_o = opa_q;
                alu_data2_o = opb_q;
                alu_op_o    = op_q;
                res_d       = alu_result_i;
                state_d     = WB;
            end
            WB: begin
                reg_wen_o     = (rd_q != '0);
                reg_waddr_o   = rd_q;
                reg_wdata_o   = res_q;
                done_valid_o  = 1'b1;
                done_id_o     = id_q;
                done_result_o = res_q;
                state_d       = done_ready_i ? IDLE : RESP;
            end
            RESP: begin
                done_valid_o  = 1'b1;
                done_id_o     = id_q;
                done_result_o = res_q;
                if (done_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            id_q    <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            id_q    <= id_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: doc/alu_reg_sched.md
ALU_REG_SCHED -- requirements
Module: alu_reg_sched

Interface
REQ-001 Parameter: DATA_W, 32, width of operands, results and register data.
REQ-002 Parameter: RADDR_W, 5, register-file address width.
REQ-003 Ports (name direction width meaning):
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmdN_valid_i  in  1  requester N (N=0,1) command valid.
- cmdN_ready_o  out  1  requester N command accepted this cycle.
- cmdN_op_i  in  4  ALU op (shared ALU_OP_* encoding, passed through unmodified).
- cmdN_rs1_i, cmdN_rs2_i, cmdN_rd_i  in  RADDR_W each  source/destination registers.
- reg_raddr1_o, reg_raddr2_o  out  RADDR_W  register-file read addresses.
- reg_rdata1_i, reg_rdata2_i  in  DATA_W  combinational register-file read data.
- reg_wen_o  out  1  register-file write enable (written on rising clk).
- reg_waddr_o  out  RADDR_W, reg_wdata_o  out  DATA_W  write address/data.
- alu_data1_o, alu_data2_o  out  DATA_W, alu_op_o  out  4  ALU inputs.
- alu_result_i  in  DATA_W  combinational ALU result.
- done_valid_o  out  1, done_id_o  out  1, done_result_o  out  DATA_W  completion response.
- done_ready_i  in  1  response consumer ready.
- busy_o  out  1  high whenever state != IDLE.

Function
REQ-004 FSM states IDLE, READ, EXEC, WB, RESP; exactly one command in flight.
REQ-005 IDLE: if any cmdN_valid_i, grant one requester; granted cmdN_ready_o=1 that cycle (combinational from valid and grant); op/rs1/rs2/rd latched; -> READ. Ungranted ready=0.
REQ-006 cmdN_ready_o SHALL be 0 in every non-IDLE state.
REQ-007 READ: reg_raddr1_o/2_o = latched rs1/rs2; rdata captured into operand registers at cycle end; -> EXEC.
REQ-008 EXEC: alu_data1_o/2_o = captured operands, alu_op_o = latched op; alu_result_i captured; -> WB.
REQ-009 WB: reg_wen_o=1 for exactly this cycle, reg_waddr_o=rd, reg_wdata_o=result; reg_wen_o SHALL be 0 when rd==0; done_valid_o=1.
REQ-010 WB: done_ready_i=1 -> IDLE, else -> RESP; RESP holds done_valid_o/done_id_o/done_result_o stable until done_ready_i=1, then -> IDLE.
REQ-011 Latency: acceptance cycle T, write and first done_valid_o at T+3; next acceptance no earlier than T+4.
REQ-012 Outside their states, reg_wen_o=0, done_valid_o=0; read addresses, ALU inputs and write address/data SHALL be 0.
REQ-013 Command valid deasserting before grant is permitted; no state change.
REQ-014 Same register as rs1, rs2 and rd SHALL read pre-write values.

Reset
REQ-015 reset low, any state: -> IDLE immediately; all outputs 0; operand/result registers 0; arbitration pointer "last served" = 1.
REQ-016 Reset during READ/EXEC/WB/RESP aborts the command: no write, no response after release.

Configuration
REQ-017 Macro ALU_SCHED_RR_ARB_EN defined: round-robin; both valid in IDLE -> grant requester != last served; pointer updates on each grant.
REQ-018 Macro undefined: fixed priority, requester 0 wins whenever valid; no pointer state.

Verification (bench: gen_regs and alu models, backdoor preload)
REQ-019 x1=0x2, x2=0x20; cmd0 ADD rs1=1 rs2=2 rd=3, done_ready=1 -> ready at T, wen at T+3 waddr=3 wdata=0x22, done_id=0, x3 reads 0x22.
REQ-020 x4=0x80000000, x5=0x1; cmd1 SRA rd=6, done_ready=0 for 3 cycles -> RESP held 0xc0000000 stable, busy_o=1, no second write.
REQ-021 Both requesters valid continuously, 4 commands -> with RR_ARB_EN grants 0,1,0,1; without, 0,0,0,0 and cmd1_ready_o never 1.
REQ-022 cmd0 SUB rs1=2 rs2=1 rd=0 -> done_result 0x1e, reg_wen_o stays 0, x0 reads 0.
REQ-023 reset asserted in EXEC -> outputs 0 immediately, rd unchanged, no done_valid_o after release; next command completes normally.
REQ-024 cmd0 ADD rs1=1 rs2=1 rd=1 with x1=0x2 -> x1=0x4 (pre-write operands).
